fp_cmp_cvt_unit: RTL
====================

# fp_cmp_cvt_unit

Execution-side consumer of the 4-bit FP ALU control code produced by the FP ALU decoder. It performs the non-arithmetic RV32F operations: MIN, MAX, FLE, FLT, FEQ, FCLASS and FCVT.S.W. The unit sits in the FP execute stage beside the add/mul datapath and uses a valid/ready handshake on both sides. Compare, min/max and class finish in one cycle. FCVT.S.W normalises iteratively, one bit per cycle.

## Interface
- No parameters; width fixed at 32 (binary32).
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  unit can accept (high only in IDLE)
- alu_ctrl  in  4  0010 MIN, 0011 MAX, 0100 FLE, 0101 FLT, 0110 FEQ, 0111 CLASS, 1111 CVT.S.W
- op_a  in  32  rs1 operand (float, or signed int for CVT)
- op_b  in  32  rs2 operand (ignored by CLASS/CVT)
- out_valid  out  1  result held valid
- out_ready  in  1  consumer accepts result
- result  out  32  float result, or 0/1 for compares, or one-hot class in [9:0]
- fflags  out  5  {NV,DZ,OF,UF,NX}; bit4=NV, bit0=NX
- illegal  out  1  alu_ctrl was not one of the seven codes above

## Operation
- FSM states: IDLE, CVT_NORM, DONE. Reset enters IDLE.
- IDLE, on accept (in_valid & in_ready):
  - Compare/min/max/class/illegal: compute combinationally, register result/fflags/illegal, go to DONE.
  - CVT with op_a==0: result 0x00000000, go to DONE.
  - CVT otherwise: sign <= op_a[31]; mant <= |op_a| (32-bit unsigned; 0x80000000 stays 0x80000000); exp <= 158; go to CVT_NORM.
- CVT_NORM:
  - If mant[31]==0: mant <<= 1, exp -= 1, stay.
  - Else round to nearest even. Kept bits are mant[31:8], guard is mant[7], sticky is OR mant[6:0]. Increment when guard & (sticky | mant[8]).
  - A carry out of 24 bits increments exp.
  - result = {sign, exp[7:0], rounded[22:0]}; NX = guard|sticky; go to DONE.
- DONE: out_valid=1, outputs stable. On out_ready go to IDLE.
- FEQ: NV only on signalling NaN. FLT/FLE: NV on any NaN. Any NaN operand gives result 0. +0 and -0 compare equal.
- MIN/MAX:
  - -0 < +0.
  - One NaN operand: return the other operand.
  - Both NaN: return 0x7FC00000.
  - NV if either operand is a signalling NaN.
- CLASS bits: 0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN. result[31:10]=0. fflags=0.
- Illegal code: result 0, fflags 0, illegal=1, same 1-cycle latency.
- DZ/OF/UF are always 0.

## Timing
- Reset values: out_valid 0, in_ready 1 (IDLE), result 0, fflags 0, illegal 0, internal mant/exp/sign 0.
- Reset asserted in any state aborts the operation and returns to IDLE. A pending result is discarded.
- Accept in cycle N:
  - Non-CVT and CVT of zero: out_valid at N+1.
  - CVT nonzero: out_valid at N+2+lz, where lz = leading zeros of |op_a| (max N+33 for |op_a|=1).
- out_valid stays high with result/fflags/illegal stable until out_ready is sampled high; out_valid drops the next cycle.
- No overlap: in_ready is 0 in CVT_NORM and DONE. Best throughput is one op per 2 cycles.
- alu_ctrl/op_a/op_b are sampled only at accept. Changes at other times are ignored.

## Structure
- Shared package fp_pkg holds:
  - ALU control code constants (shared with the decoder)
  - canonical NaN 0x7FC00000
  - fflags bit indices
  - class bit indices
- Sub-module fp_classify: combinational. Takes a 32-bit operand and returns the one-hot class[9:0]. Two instances (op_a, op_b) supply the NaN/zero/sign detection for compare and min/max.

## Test plan
- FLT op_a=0x3F800000, op_b=0x40000000, out_ready=1 -> result 1, fflags 0, out_valid at N+1.
- FEQ op_a=0x7F800001, op_b=0x3F800000 -> result 0, fflags 0x10; FLE with op_a=0x7FC00000 also gives fflags 0x10.
- MIN +0/-0 -> 0x80000000; MAX 0x7FC00000/0x40400000 -> 0x40400000, fflags 0; CLASS 0x00000001 -> 0x020.
- CVT 1 -> 0x3F800000 at N+33; 0x80000000 -> 0xCF000000 at N+2; 0x7FFFFFFF -> 0x4F000000, fflags 0x01 at N+3; 0 -> 0 at N+1.
- Backpressure: hold out_ready=0 for 5 cycles after FEQ 1.0,1.0 -> out_valid and result=1 held, in_ready=0; accepted on release, in_ready high the next cycle.
- Assert rst mid-CVT of 1 (cycle N+10) -> next edge: out_valid 0, in_ready 1, result 0; a new FLT completes normally. alu_ctrl=0001 -> illegal=1, result 0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP definitions: ALU control codes (common with the FP ALU decoder),
// canonical NaN, fflags bit positions, one-hot class bit positions and the
// state encoding of the compare/convert unit.
package fp_pkg;

  // FP ALU control codes
  localparam logic [3:0] ALU_MIN    = 4'b0010;
  localparam logic [3:0] ALU_MAX    = 4'b0011;
  localparam logic [3:0] ALU_FLE    = 4'b0100;
  localparam logic [3:0] ALU_FLT    = 4'b0101;
  localparam logic [3:0] ALU_FEQ    = 4'b0110;
  localparam logic [3:0] ALU_CLASS  = 4'b0111;
  localparam logic [3:0] ALU_CVT_SW = 4'b1111;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // fflags = {NV,DZ,OF,UF,NX}
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // one-hot class bits
  localparam int CLS_NEG_INF  = 0;
  localparam int CLS_NEG_NORM = 1;
  localparam int CLS_NEG_SUB  = 2;
  localparam int CLS_NEG_ZERO = 3;
  localparam int CLS_POS_ZERO = 4;
  localparam int CLS_POS_SUB  = 5;
  localparam int CLS_POS_NORM = 6;
  localparam int CLS_POS_INF  = 7;
  localparam int CLS_SNAN     = 8;
  localparam int CLS_QNAN     = 9;

  // biased exponent of 2^31: the MSB of a 32-bit magnitude
  localparam logic [7:0] CVT_EXP_INIT = 8'd158;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CVT_NORM,
    ST_DONE
  } unit_state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational binary32 classifier.
//   op  in  32  operand
//   cls out 10  one-hot class (bit positions from fp_pkg CLS_*)
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] op,
  output logic [9:0]  cls
);

  logic exp_ones, exp_zero, frac_zero;

  assign exp_ones  = &op[30:23];
  assign exp_zero  = ~|op[30:23];
  assign frac_zero = ~|op[22:0];

  always_comb begin
    cls = '0;
    if (exp_ones) begin
      if (frac_zero)  cls[op[31] ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
      else if (op[22]) cls[CLS_QNAN] = 1'b1;
      else             cls[CLS_SNAN] = 1'b1;
    end else if (exp_zero) begin
      if (frac_zero) cls[op[31] ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
      else           cls[op[31] ? CLS_NEG_SUB  : CLS_POS_SUB]  = 1'b1;
    end else begin
      cls[op[31] ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_cmp_cvt_unit.sv
// Non-arithmetic RV32F execute unit: MIN/MAX, FLE/FLT/FEQ, FCLASS (one cycle)
// and FCVT.S.W (normalised one bit per cycle, then rounded to nearest even).
//   clk, rst          clock, async active-high reset
//   in_valid/in_ready request handshake (ready only while idle)
//   alu_ctrl          4-bit FP ALU control code
//   op_a, op_b        rs1 / rs2 operands, sampled only at accept
//   out_valid/out_ready result handshake; outputs held until out_ready
//   result, fflags    registered result and {NV,DZ,OF,UF,NX}
//   illegal           alu_ctrl was not a supported code
module fp_cmp_cvt_unit
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  fflags,
  output logic        illegal
);

  localparam int NUM_OPS = 2;

  unit_state_t state;
  logic [31:0] mant;
  logic [7:0]  exp;
  logic        sign;

  // ---------------------------------------------------------------------
  // Operand classification: one classifier per source operand
  // ---------------------------------------------------------------------
  logic [NUM_OPS-1:0][31:0] ops;
  logic [NUM_OPS-1:0][9:0]  cls;

  assign ops = {op_b, op_a};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_cls
      fp_classify u_cls (.op(ops[gi]), .cls(cls[gi]));
    end
  endgenerate

  logic nan_a, nan_b, snan_any, zero_both, lt_raw, lt, eq;

  assign nan_a     = cls[0][CLS_SNAN] | cls[0][CLS_QNAN];
  assign nan_b     = cls[1][CLS_SNAN] | cls[1][CLS_QNAN];
  assign snan_any  = cls[0][CLS_SNAN] | cls[1][CLS_SNAN];
  assign zero_both = (cls[0][CLS_NEG_ZERO] | cls[0][CLS_POS_ZERO]) &
                     (cls[1][CLS_NEG_ZERO] | cls[1][CLS_POS_ZERO]);

  // Sign-magnitude ordering on raw bits; orders -0 below +0, which is what
  // min/max want. The IEEE compares mask that out with zero_both.
  assign lt_raw = (op_a[31] != op_b[31]) ? op_a[31] :
                  (op_a[31] ? (op_a[30:0] > op_b[30:0]) : (op_a[30:0] < op_b[30:0]));
  assign lt     = lt_raw & ~zero_both;
  assign eq     = (op_a == op_b) | zero_both;

  logic [31:0] cmp_result;
  logic [4:0]  cmp_flags;
  logic        cmp_illegal;

  always_comb begin
    cmp_result  = '0;
    cmp_flags   = '0;
    cmp_illegal = 1'b0;
    case (alu_ctrl)
      ALU_MIN, ALU_MAX: begin
        if (nan_a & nan_b) cmp_result = CANON_NAN;
        else if (nan_a)    cmp_result = op_b;
        else if (nan_b)    cmp_result = op_a;
        else if (alu_ctrl == ALU_MIN) cmp_result = lt_raw ? op_a : op_b;
        else                          cmp_result = lt_raw ? op_b : op_a;
        cmp_flags[FLAG_NV] = snan_any;
      end
      ALU_FLE, ALU_FLT: begin
        if (!(nan_a | nan_b))
          cmp_result[0] = (alu_ctrl == ALU_FLT) ? lt : (lt | eq);
        cmp_flags[FLAG_NV] = nan_a | nan_b;
      end
      ALU_FEQ: begin
        cmp_result[0]      = ~(nan_a | nan_b) & eq;
        cmp_flags[FLAG_NV] = snan_any;
      end
      ALU_CLASS: cmp_result[9:0] = cls[0];
      default:   cmp_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // FCVT.S.W rounding of the normalised magnitude (mant[31] set)
  // ---------------------------------------------------------------------
  logic        guard, sticky, round_inc;
  logic [24:0] rnd_sum;
  logic [22:0] rnd_frac;
  logic [7:0]  rnd_exp;

  assign guard     = mant[7];
  assign sticky    = |mant[6:0];
  assign round_inc = guard & (sticky | mant[8]);
  assign rnd_sum   = {1'b0, mant[31:8]} + 25'(round_inc);
  // a carry out only happens from all-ones, so the fraction becomes zero
  assign rnd_frac  = rnd_sum[24] ? rnd_sum[23:1] : rnd_sum[22:0];
  assign rnd_exp   = exp + 8'(rnd_sum[24]);

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      fflags    <= '0;
      illegal   <= 1'b0;
      mant      <= '0;
      exp       <= '0;
      sign      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (alu_ctrl == ALU_CVT_SW && op_a != 32'd0) begin
              sign  <= op_a[31];
              mant  <= op_a[31] ? (~op_a + 32'd1) : op_a;
              exp   <= CVT_EXP_INIT;
              state <= ST_CVT_NORM;
            end else begin
              // CVT of zero yields the all-zero compare defaults
              result    <= (alu_ctrl == ALU_CVT_SW) ? 32'd0 : cmp_result;
              fflags    <= (alu_ctrl == ALU_CVT_SW) ? 5'd0 : cmp_flags;
              illegal   <= (alu_ctrl == ALU_CVT_SW) ? 1'b0 : cmp_illegal;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_CVT_NORM: begin
          if (!mant[31]) begin
            mant <= mant << 1;
            exp  <= exp - 8'd1;
          end else begin
            result    <= {sign, rnd_exp, rnd_frac};
            fflags    <= {4'b0000, guard | sticky};
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
